wb_bus_arbiter_xbar: RTL and testbench

Parametrised shared-bus Wishbone interconnect joining M master sockets to S slave sockets. Round-robin arbitration with bus lock for the whole cycle; granted master's request is broadcast to slaves and qualified per slave by an externally supplied one-hot address decode. The block generates bus errors itself for decode misses and for slaves that never respond (watchdog timeout). Sits between the SoC's master and slave sockets, driven by the system clock/reset sockets.

---
 rtl/wb_bus_arbiter_xbar.sv | 206 ++++++++++++++++++++
 tb/tb_wb_bus_arbiter_xbar.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bus_arbiter_xbar.sv
// Shared-bus Wishbone interconnect: round-robin master arbitration with cycle lock,
// externally decoded slave select, internal decode-miss and watchdog bus errors.
module wb_bus_arbiter_xbar #(
    parameter int M       = 4,
    parameter int S       = 4,
    parameter int Dw      = 32,
    parameter int Aw      = 32,
    parameter int SELw    = 4,
    parameter int TAGw    = 3,
    parameter int CTIw    = 3,
    parameter int BTEw    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [M*Aw-1:0]   m_adr_i,
    input  logic [M*Dw-1:0]   m_dat_i,
    input  logic [M*SELw-1:0] m_sel_i,
    input  logic [M*TAGw-1:0] m_tag_i,
    input  logic [M*CTIw-1:0] m_cti_i,
    input  logic [M*BTEw-1:0] m_bte_i,
    input  logic [M-1:0]      m_we_i,
    input  logic [M-1:0]      m_stb_i,
    input  logic [M-1:0]      m_cyc_i,
    output logic [M*Dw-1:0]   m_dat_o,
    output logic [M-1:0]      m_ack_o,
    output logic [M-1:0]      m_err_o,
    output logic [M-1:0]      m_rty_o,
    output logic [Aw-1:0]     s_adr_o,
    output logic [Dw-1:0]     s_dat_o,
    output logic [SELw-1:0]   s_sel_o,
    output logic [TAGw-1:0]   s_tag_o,
    output logic [CTIw-1:0]   s_cti_o,
    output logic [BTEw-1:0]   s_bte_o,
    output logic              s_we_o,
    output logic [S-1:0]      s_cyc_o,
    output logic [S-1:0]      s_stb_o,
    input  logic [S*Dw-1:0]   s_dat_i,
    input  logic [S-1:0]      s_ack_i,
    input  logic [S-1:0]      s_err_i,
    input  logic [S-1:0]      s_rty_i,
    output logic [Aw-1:0]     grant_adr_o,
    input  logic [S-1:0]      s_sel_one_hot_i,
    output logic [M-1:0]      grant_o,
    output logic              timeout_o
);

    localparam int OW = (M > 1) ? $clog2(M) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);

    typedef enum logic {ST_IDLE, ST_OWNED} state_t;

    state_t          state_q, state_d;
    logic [M-1:0]    grant_q, grant_d;
    logic [OW-1:0]   last_owner_q, last_owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            timeout_q, timeout_d;

    logic            owned, owner_cyc, owner_stb;
    logic            rr_found, lo_found, hi_found;
    logic [OW-1:0]   rr_idx, lo_idx, hi_idx;
    logic            sel_valid;
    logic [S-1:0]    sel_v;
    logic            slv_ack, slv_err, slv_rty;
    logic            wd_active, wd_fire, dec_err;
    logic [Dw-1:0]   rdata;

    assign owned     = |grant_q;
    assign owner_cyc = |(grant_q & m_cyc_i);
    assign owner_stb = |(grant_q & m_stb_i);

    // Round robin: lowest requester above last_owner wins, else lowest overall (wrap).
    always_comb begin
        lo_found = 1'b0;
        hi_found = 1'b0;
        lo_idx   = '0;
        hi_idx   = '0;
        for (int i = M - 1; i >= 0; i--) begin
            if (m_cyc_i[i]) begin
                lo_found = 1'b1;
                lo_idx   = OW'(i);
                if (i > int'(last_owner_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = OW'(i);
                end
            end
        end
        rr_found = lo_found;
        rr_idx   = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_owner_d = last_owner_q;
        case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    grant_d      = M'(1) << rr_idx;
                    last_owner_d = rr_idx;
                    state_d      = ST_OWNED;
                end
            end
            ST_OWNED: begin
                // Owner keeps the bus for as long as it holds cyc.
                if (!owner_cyc) begin
                    if (rr_found) begin
                        grant_d      = M'(1) << rr_idx;
                        last_owner_d = rr_idx;
                    end else begin
                        grant_d = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_tag_o = '0;
        s_cti_o = '0;
        s_bte_o = '0;
        s_we_o  = 1'b0;
        for (int i = 0; i < M; i++) begin
            if (grant_q[i]) begin
                s_adr_o = m_adr_i[i*Aw +: Aw];
                s_dat_o = m_dat_i[i*Dw +: Dw];
                s_sel_o = m_sel_i[i*SELw +: SELw];
                s_tag_o = m_tag_i[i*TAGw +: TAGw];
                s_cti_o = m_cti_i[i*CTIw +: CTIw];
                s_bte_o = m_bte_i[i*BTEw +: BTEw];
                s_we_o  = m_we_i[i];
            end
        end
    end

    assign grant_adr_o = s_adr_o;

    assign sel_valid = (s_sel_one_hot_i != '0) &&
                       ((s_sel_one_hot_i & (s_sel_one_hot_i - S'(1))) == '0);
    assign sel_v     = sel_valid ? s_sel_one_hot_i : '0;

    assign slv_ack = |(s_ack_i & sel_v);
    assign slv_err = |(s_err_i & sel_v);
    assign slv_rty = |(s_rty_i & sel_v);

    always_comb begin
        rdata = '0;
        for (int j = 0; j < S; j++) begin
            if (sel_v[j]) rdata = s_dat_i[j*Dw +: Dw];
        end
        if (!owned) rdata = '0;
    end

    assign m_dat_o = {M{rdata}};
    assign m_ack_o = grant_q & {M{slv_ack}};
    assign m_rty_o = grant_q & {M{slv_rty}};
    assign m_err_o = grant_q & {M{slv_err | err_q}};

    assign s_cyc_o = {S{owner_cyc}} & sel_v;
    // The watchdog's error cycle withdraws the strobe from the silent slave.
    assign s_stb_o = {S{owner_cyc & owner_stb & ~timeout_q}} & sel_v;

    // err_q doubles as the response that ends a watched access.
    assign wd_active = owner_cyc & owner_stb & sel_valid & ~slv_ack & ~slv_err & ~slv_rty & ~err_q;
    assign wd_fire   = (TIMEOUT != 0) && wd_active && (cnt_q == TO_V);
    assign dec_err   = owner_cyc & owner_stb & ~sel_valid & ~err_q;

    always_comb begin
        cnt_d     = cnt_q + CW'(1);
        if (TIMEOUT == 0 || !wd_active || wd_fire || (grant_d != grant_q)) cnt_d = '0;
        err_d     = dec_err | wd_fire;
        timeout_d = wd_fire;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_owner_q <= OW'(M - 1);
            cnt_q        <= '0;
            err_q        <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            timeout_q    <= timeout_d;
        end
    end

    assign grant_o   = grant_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_wb_bus_arbiter_xbar.sv
// Bench for wb_bus_arbiter_xbar: behavioural masters/slaves/decoder with a response
// scoreboard and a log of grant changes.
module tb_wb_bus_arbiter_xbar;

    localparam int M  = 4;
    localparam int S  = 4;
    localparam int DW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic reset;

    logic [M*AW-1:0] m_adr_i;
    logic [M*DW-1:0] m_dat_i;
    logic [M*4-1:0]  m_sel_i;
    logic [M*3-1:0]  m_tag_i, m_cti_i;
    logic [M*2-1:0]  m_bte_i;
    logic [M-1:0]    m_we_i, m_stb_i, m_cyc_i;
    logic [M*DW-1:0] m_dat_o;
    logic [M-1:0]    m_ack_o, m_err_o, m_rty_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [3:0]      s_sel_o;
    logic [2:0]      s_tag_o, s_cti_o;
    logic [1:0]      s_bte_o;
    logic            s_we_o;
    logic [S-1:0]    s_cyc_o, s_stb_o;
    logic [S*DW-1:0] s_dat_i;
    logic [S-1:0]    s_ack_i, s_err_i, s_rty_i;
    logic [AW-1:0]   grant_adr_o;
    logic [S-1:0]    s_sel_one_hot_i;
    logic [M-1:0]    grant_o;
    logic            timeout_o;

    wb_bus_arbiter_xbar #(
        .M(M), .S(S), .Dw(DW), .Aw(AW), .SELw(4), .TAGw(3), .CTIw(3), .BTEw(2), .TIMEOUT(8)
    ) dut (
        .clk(clk), .reset(reset),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_tag_i(m_tag_i),
        .m_cti_i(m_cti_i), .m_bte_i(m_bte_i), .m_we_i(m_we_i), .m_stb_i(m_stb_i),
        .m_cyc_i(m_cyc_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .m_rty_o(m_rty_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_tag_o(s_tag_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .s_err_i(s_err_i), .s_rty_i(s_rty_i), .grant_adr_o(grant_adr_o),
        .s_sel_one_hot_i(s_sel_one_hot_i), .grant_o(grant_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          m;
        bit          err;
        logic [31:0] dat;
    } exp_t;

    exp_t         sb[$];
    logic [M-1:0] gseq[$];
    logic [M-1:0] gexp[$];
    logic [M-1:0] prev_g;

    logic [AW-1:0] madr [M];
    int            mcnt [M];
    logic [S-1:0]  mute, dec_val;
    logic          dec_force;
    logic [DW-1:0] sdat [S] = '{32'h1111_0000, 32'hDEAD_BEEF, 32'h2222_2222, 32'h3333_3333};

    int n_chk = 0;
    int n_err = 0;

    assign m_sel_i = '1;
    assign m_tag_i = '0;
    assign m_cti_i = '0;
    assign m_bte_i = '0;
    assign m_we_i  = '0;
    assign s_err_i = '0;
    assign s_rty_i = '0;

    always_comb begin
        for (int i = 0; i < M; i++) begin
            m_adr_i[i*AW +: AW] = madr[i];
            m_dat_i[i*DW +: DW] = 32'hA000_0000 + i;
        end
        for (int j = 0; j < S; j++) s_dat_i[j*DW +: DW] = sdat[j];
    end

    // Address decoder: adr[13:12] picks the slave unless a raw value is forced.
    always_comb begin
        if (dec_force)          s_sel_one_hot_i = dec_val;
        else if (grant_o != 0)  s_sel_one_hot_i = 4'b0001 << grant_adr_o[13:12];
        else                    s_sel_one_hot_i = '0;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int m, input bit err, input logic [31:0] dat);
        exp_t e;
        e.m = m; e.err = err; e.dat = dat;
        sb.push_back(e);
    endtask

    task automatic mreq(input int i, input logic [AW-1:0] adr, input int n);
        madr[i]    = adr;
        mcnt[i]    = n;
        m_cyc_i[i] = 1'b1;
        m_stb_i[i] = 1'b1;
    endtask

    task automatic monitor();
        logic [M-1:0] r;
        exp_t         e;
        r = m_ack_o | m_err_o | m_rty_o;
        if (r != 0) begin
            if (sb.size() == 0) chk("sb_extra", r, 0);
            else begin
                e = sb.pop_front();
                chk("resp_who", r, 4'b0001 << e.m);
                chk("resp_err", m_err_o != 0, e.err);
                if (!e.err) chk("resp_dat", m_dat_o[e.m*DW +: DW], e.dat);
            end
        end
        if (grant_o != prev_g && grant_o != 0) gseq.push_back(grant_o);
        prev_g = grant_o;
    endtask

    // One clock: masters/slaves react to what they saw before the edge, then sample.
    task automatic tick();
        logic [M-1:0] rs;
        logic [S-1:0] ss;
        rs = m_ack_o | m_err_o | m_rty_o;
        ss = s_stb_o;
        @(posedge clk); #1;
        for (int i = 0; i < M; i++) begin
            if (mcnt[i] > 0 && rs[i]) begin
                mcnt[i]--;
                if (mcnt[i] == 0) begin
                    m_cyc_i[i] = 1'b0;
                    m_stb_i[i] = 1'b0;
                end
            end
        end
        for (int j = 0; j < S; j++) s_ack_i[j] = ss[j] & ~s_ack_i[j] & ~mute[j];
        @(negedge clk);
        monitor();
    endtask

    function automatic bit idle();
        return (m_cyc_i == 0) && (grant_o == 0) && (sb.size() == 0);
    endfunction

    task automatic drain(input string tag, input int max);
        int k;
        bit done;
        k = 0;
        done = idle();
        while (!done && k < max) begin
            tick();
            k++;
            done = idle();
        end
        chk(tag, done, 1);
    endtask

    task automatic cmp_gseq(input string tag);
        chk({tag, "_len"}, gseq.size(), gexp.size());
        for (int k = 0; k < gexp.size() && k < gseq.size(); k++) chk(tag, gseq[k], gexp[k]);
        gseq.delete();
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        m_cyc_i   = '0;
        m_stb_i   = '0;
        s_ack_i   = '0;
        mute      = '0;
        dec_force = 1'b0;
        for (int i = 0; i < M; i++) mcnt[i] = 0;
        sb.delete();
        gseq.delete();
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        prev_g = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, grant_o, 0);
        chk({tag, "_resp"}, m_ack_o | m_err_o | m_rty_o, 0);
        chk({tag, "_scyc"}, s_cyc_o, 0);
        chk({tag, "_sstb"}, s_stb_o, 0);
        chk({tag, "_sadr"}, s_adr_o, 0);
        chk({tag, "_gadr"}, grant_adr_o, 0);
        chk({tag, "_mdat"}, m_dat_o, 0);
        chk({tag, "_tmo"}, timeout_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int first, to_at, n_to;
        // Reset with every input shouting: outputs must still be quiet.
        reset     = 1'b0;
        m_cyc_i   = '1;
        m_stb_i   = '1;
        s_ack_i   = '1;
        mute      = '0;
        dec_force = 1'b1;
        dec_val   = 4'b0010;
        prev_g    = '0;
        for (int i = 0; i < M; i++) begin
            madr[i] = 32'h1000;
            mcnt[i] = 0;
        end
        repeat (2) @(negedge clk);
        chk_all_zero("rst");
        do_reset();

        // Single read through slave 1.
        mreq(0, 32'h1000, 1);
        push(0, 0, 32'hDEAD_BEEF);
        chk("s1_idle", grant_o, 0);
        tick();
        chk("s1_grant", grant_o, 4'b0001);
        chk("s1_stb", s_stb_o, 4'b0010);
        chk("s1_cyc", s_cyc_o, 4'b0010);
        chk("s1_adr", s_adr_o, 32'h1000);
        chk("s1_gadr", grant_adr_o, 32'h1000);
        chk("s1_wdat", s_dat_o, 32'hA000_0000);
        chk("s1_sel", s_sel_o, 4'hF);
        tick();
        chk("s1_sack", s_ack_i, 4'b0010);
        chk("s1_ack", m_ack_o, 4'b0001);
        chk("s1_rdat_rep", m_dat_o[3*DW +: DW], 32'hDEAD_BEEF);
        drain("s1_drain", 10);

        // Everyone requests at once: strict rotation.
        do_reset();
        for (int i = 0; i < M; i++) begin
            mreq(i, i << 12, 1);
            push(i, 0, sdat[i]);
        end
        drain("s2_drain", 40);
        mreq(0, 32'h2000, 1);
        push(0, 0, sdat[2]);
        drain("s2b_drain", 10);
        gexp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        cmp_gseq("s2_gseq");

        // m2 holds the bus over three transfers.
        do_reset();
        mreq(2, 32'h2000, 3);
        repeat (3) push(2, 0, sdat[2]);
        tick();
        chk("s3_lock0", grant_o, 4'b0100);
        mreq(0, 32'h0000, 1);
        mreq(1, 32'h1000, 1);
        push(0, 0, sdat[0]);
        push(1, 0, sdat[1]);
        repeat (4) begin
            tick();
            chk("s3_lock", grant_o, 4'b0100);
        end
        drain("s3_drain", 40);
        gexp = '{4'b0100, 4'b0001, 4'b0010};
        cmp_gseq("s3_gseq");

        // Decode misses: no select, then multi-hot with stb held.
        dec_force = 1'b1;
        dec_val   = 4'b0000;
        mreq(1, 32'h1000, 1);
        push(1, 1, 0);
        tick();
        chk("s4a_grant", grant_o, 4'b0010);
        chk("s4a_stb", s_stb_o, 0);
        chk("s4a_noerr", m_err_o, 0);
        tick();
        chk("s4a_err", m_err_o, 4'b0010);
        chk("s4a_stb2", s_stb_o, 0);
        drain("s4a_drain", 10);
        dec_val = 4'b0110;
        mreq(1, 32'h1000, 2);
        push(1, 1, 0);
        push(1, 1, 0);
        tick();
        chk("s4b_noerr1", m_err_o, 0);
        chk("s4b_stb1", s_stb_o, 0);
        tick();
        chk("s4b_err1", m_err_o, 4'b0010);
        tick();
        chk("s4b_noerr2", m_err_o, 0);
        chk("s4b_stb3", s_stb_o, 0);
        tick();
        chk("s4b_err2", m_err_o, 4'b0010);
        drain("s4b_drain", 10);

        // Slave 3 never answers: watchdog.
        dec_force = 1'b0;
        mute      = 4'b1000;
        mreq(0, 32'h3000, 1);
        push(0, 1, 0);
        first = -1;
        to_at = -1;
        n_to  = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (first < 0 && s_stb_o != 0) first = k;
            if (timeout_o) begin
                n_to++;
                to_at = k;
                chk("s5_to_stb", s_stb_o, 0);
                chk("s5_to_err", m_err_o, 4'b0001);
            end
        end
        chk("s5_delay", to_at - first, 9);
        chk("s5_pulses", n_to, 1);
        mute = '0;
        drain("s5_drain", 10);

        // Reset in the middle of a burst.
        mreq(1, 32'h1000, 3);
        repeat (3) push(1, 0, sdat[1]);
        repeat (3) tick();
        chk("s6_busy", grant_o, 4'b0010);
        reset = 1'b0;
        #1;
        chk_all_zero("s6_rst");
        do_reset();
        mreq(0, 32'h0000, 1);
        mreq(3, 32'h3000, 1);
        push(0, 0, sdat[0]);
        push(3, 0, sdat[3]);
        drain("s6_drain", 30);
        gexp = '{4'b0001, 4'b1000};
        cmp_gseq("s6_gseq");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
